dfe_tap_monitor: RTL and testbench

//  Parametrised observation block for the DFE chain. Selects one of N_STAGES stage taps
//  (frac decimator, IIR notches, CIC, core output, ...). Registers the selected tap's

---
 rtl/dfe_mon_pkg.sv | 21 ++
 rtl/dfe_tap_monitor_if.sv | 13 +
 rtl/dfe_mon_cap_buf.sv | 32 +++
 rtl/dfe_tap_monitor.sv | 177 +++++++++++++++++
 tb/tb_dfe_tap_monitor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dfe_mon_pkg.sv
// Shared types and helpers for the DFE tap monitor: capture FSM encoding and
// a saturating increment used by the event counters.
package dfe_mon_pkg;

  localparam int CAP_ST_W = 2;

  typedef enum logic [CAP_ST_W-1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } cap_state_e;

  // Increments cnt unless it already holds the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
    logic [32:0] lim;
    lim = (33'd1 << width) - 33'd1;
    return ({1'b0, cnt} >= lim) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/dfe_tap_monitor_if.sv
// Bundle of the DFE stage taps: packed samples plus per-tap valid/overflow/underflow.
interface dfe_tap_monitor_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_STAGES   = 6
);
  logic [N_STAGES*DATA_WIDTH-1:0] stage_data;
  logic [N_STAGES-1:0]            stage_valid;
  logic [N_STAGES-1:0]            stage_ovf;
  logic [N_STAGES-1:0]            stage_unf;

  modport master (output stage_data, stage_valid, stage_ovf, stage_unf);
  modport slave  (input  stage_data, stage_valid, stage_ovf, stage_unf);
endinterface

// File: rtl/dfe_mon_cap_buf.sv
// Capture buffer: simple dual-port RAM with one write port and a registered read port.
module dfe_mon_cap_buf #(
  parameter  int DATA_WIDTH = 16,
  parameter  int CAP_DEPTH  = 32,
  localparam int AW         = $clog2(CAP_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [CAP_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  // Reading before the edge update gives old data on a same-address collision.
  always_comb rd_data_d = mem[rd_addr];

  // NOTE: the storage array has no reset so it maps onto RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/dfe_tap_monitor.sv
// DFE tap monitor: lane select with registered outputs, sticky flags, saturating
// counters and a triggered burst capture into dfe_mon_cap_buf.
module dfe_tap_monitor
  import dfe_mon_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int N_STAGES   = 6,
  parameter  int CNT_WIDTH  = 16,
  parameter  int CAP_DEPTH  = 32,
  localparam int SEL_WIDTH  = $clog2(N_STAGES + 1),
  localparam int AW         = $clog2(CAP_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  dfe_tap_monitor_if.slave      stage_if,
  input  logic [SEL_WIDTH-1:0]  out_sel,
  input  logic                  clr_sticky,
  input  logic                  cap_arm,
  input  logic                  cap_trig_mode,
  input  logic [AW-1:0]         cap_rd_addr,
  output logic [DATA_WIDTH-1:0] mon_out,
  output logic                  mon_valid,
  output logic                  mon_ovf,
  output logic                  mon_unf,
  output logic [N_STAGES-1:0]   sticky_ovf,
  output logic [N_STAGES-1:0]   sticky_unf,
  output logic [CNT_WIDTH-1:0]  valid_cnt,
  output logic [CNT_WIDTH-1:0]  event_cnt,
  output logic [CAP_ST_W-1:0]   cap_state,
  output logic [DATA_WIDTH-1:0] cap_rd_data
);
  logic [SEL_WIDTH-1:0]  eff_sel, sel_d, sel_q;
  logic                  sel_change;
  logic [DATA_WIDTH-1:0] lane_data;
  logic                  lane_valid, lane_ovf, lane_unf, trig;
  logic [DATA_WIDTH-1:0] mon_out_d, mon_out_q;
  logic                  mon_valid_d, mon_valid_q, mon_ovf_d, mon_ovf_q, mon_unf_d, mon_unf_q;
  logic [N_STAGES-1:0]   sticky_ovf_d, sticky_ovf_q, sticky_unf_d, sticky_unf_q;
  logic [CNT_WIDTH-1:0]  valid_cnt_d, valid_cnt_q, event_cnt_d, event_cnt_q;
  cap_state_e            state_d, state_q;
  logic [AW-1:0]         wr_ptr_d, wr_ptr_q, wr_addr;
  logic                  wr_en;

  // NOTE: every always_comb target gets a default first, so no latch can be inferred.
  always_comb begin
    eff_sel    = (out_sel > SEL_WIDTH'(N_STAGES)) ? '0 : out_sel;
    sel_change = (eff_sel != sel_q);
    lane_data  = '0;
    lane_valid = 1'b0;
    lane_ovf   = 1'b0;
    lane_unf   = 1'b0;
    for (int k = 0; k < N_STAGES; k++) begin
      if (eff_sel == SEL_WIDTH'(k + 1)) begin
        lane_data  = stage_if.stage_data[k*DATA_WIDTH +: DATA_WIDTH];
        lane_valid = stage_if.stage_valid[k];
        lane_ovf   = stage_if.stage_ovf[k];
        lane_unf   = stage_if.stage_unf[k];
      end
    end
  end

  always_comb begin
    sel_d        = eff_sel;
    mon_out_d    = lane_data;
    mon_valid_d  = lane_valid & ~sel_change;
    mon_ovf_d    = lane_ovf;
    mon_unf_d    = lane_unf;
    // A simultaneous event beats the clear.
    sticky_ovf_d = (sticky_ovf_q & {N_STAGES{~clr_sticky}}) | stage_if.stage_ovf;
    sticky_unf_d = (sticky_unf_q & {N_STAGES{~clr_sticky}}) | stage_if.stage_unf;
    valid_cnt_d  = valid_cnt_q;
    event_cnt_d  = event_cnt_q;
    if (sel_change) begin
      valid_cnt_d = '0;
      event_cnt_d = '0;
    end else begin
      if (lane_valid)            valid_cnt_d = CNT_WIDTH'(sat_inc(32'(valid_cnt_q), CNT_WIDTH));
      if (lane_ovf || lane_unf)  event_cnt_d = CNT_WIDTH'(sat_inc(32'(event_cnt_q), CNT_WIDTH));
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    trig     = lane_valid & (cap_trig_mode ? (lane_ovf | lane_unf) : 1'b1);
    unique case (state_q)
      IDLE: begin
        if (cap_arm && eff_sel != '0) begin
          state_d  = ARMED;
          wr_ptr_d = '0;
        end
      end
      ARMED: begin
        if (sel_change) begin
          state_d = IDLE;
        end else if (cap_arm) begin
          wr_ptr_d = '0;
        end else if (trig) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_ptr_d = AW'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (sel_change) begin
          state_d = IDLE;
        end else if (cap_arm) begin
          state_d  = ARMED;
          wr_ptr_d = '0;
        end else if (lane_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == AW'(CAP_DEPTH - 1)) state_d = DONE;
          else                                wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      DONE: begin
        if (cap_arm) begin
          state_d  = ARMED;
          wr_ptr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update only with non-blocking assignments; all next values come from always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= '0;
      mon_out_q    <= '0;
      mon_valid_q  <= 1'b0;
      mon_ovf_q    <= 1'b0;
      mon_unf_q    <= 1'b0;
      sticky_ovf_q <= '0;
      sticky_unf_q <= '0;
      valid_cnt_q  <= '0;
      event_cnt_q  <= '0;
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
    end else begin
      sel_q        <= sel_d;
      mon_out_q    <= mon_out_d;
      mon_valid_q  <= mon_valid_d;
      mon_ovf_q    <= mon_ovf_d;
      mon_unf_q    <= mon_unf_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
      valid_cnt_q  <= valid_cnt_d;
      event_cnt_q  <= event_cnt_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  dfe_mon_cap_buf #(.DATA_WIDTH(DATA_WIDTH), .CAP_DEPTH(CAP_DEPTH)) u_cap_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (lane_data),
    .rd_addr (cap_rd_addr),
    .rd_data (cap_rd_data)
  );

  assign mon_out    = mon_out_q;
  assign mon_valid  = mon_valid_q;
  assign mon_ovf    = mon_ovf_q;
  assign mon_unf    = mon_unf_q;
  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;
  assign valid_cnt  = valid_cnt_q;
  assign event_cnt  = event_cnt_q;
  assign cap_state  = state_q;
endmodule

// File: tb/tb_dfe_tap_monitor.sv
// Directed bench for dfe_tap_monitor: vector table for the data path, flags and
// counters, plus hand sequences for capture, reset abort and counter saturation.
module tb_dfe_tap_monitor;
  localparam int DW = 16;
  localparam int NS = 6;

  logic        clk;
  logic        rst;
  logic [2:0]  out_sel;
  logic        clr_sticky, cap_arm, cap_trig_mode;
  logic [4:0]  cap_rd_addr;
  logic [15:0] mon_out, valid_cnt, event_cnt, cap_rd_data;
  logic        mon_valid, mon_ovf, mon_unf;
  logic [5:0]  sticky_ovf, sticky_unf;
  logic [1:0]  cap_state;

  int n_tests = 0;
  int n_fail  = 0;

  dfe_tap_monitor_if #(.DATA_WIDTH(DW), .N_STAGES(NS)) tap_if ();

  dfe_tap_monitor #(.DATA_WIDTH(DW), .N_STAGES(NS), .CNT_WIDTH(16), .CAP_DEPTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stage_if      (tap_if),
    .out_sel       (out_sel),
    .clr_sticky    (clr_sticky),
    .cap_arm       (cap_arm),
    .cap_trig_mode (cap_trig_mode),
    .cap_rd_addr   (cap_rd_addr),
    .mon_out       (mon_out),
    .mon_valid     (mon_valid),
    .mon_ovf       (mon_ovf),
    .mon_unf       (mon_unf),
    .sticky_ovf    (sticky_ovf),
    .sticky_unf    (sticky_unf),
    .valid_cnt     (valid_cnt),
    .event_cnt     (event_cnt),
    .cap_state     (cap_state),
    .cap_rd_data   (cap_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] base;
    logic [5:0]  v, o, u;
    logic        clr;
    logic [15:0] e_out;
    logic        e_v, e_o, e_u;
    logic [5:0]  e_so, e_su;
    logic [15:0] e_vc, e_ec;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane k carries base + k*0x100.
  task automatic set_taps(input logic [15:0] base, input logic [5:0] v, input logic [5:0] o,
                          input logic [5:0] u);
    for (int k = 0; k < NS; k++) tap_if.stage_data[k*DW +: DW] = base + 16'(k * 16'h0100);
    tap_if.stage_valid = v;
    tap_if.stage_ovf   = o;
    tap_if.stage_unf   = u;
  endtask

  task automatic set_all(input logic [15:0] val, input logic [5:0] v, input logic [5:0] o);
    for (int k = 0; k < NS; k++) tap_if.stage_data[k*DW +: DW] = val;
    tap_if.stage_valid = v;
    tap_if.stage_ovf   = o;
    tap_if.stage_unf   = '0;
  endtask

  initial begin
    //          sel   base      v        o        u        clr   out       v  o  u  so       su       vc  ec
    vecs[0]  = '{3'd2, 16'h7EF0, 6'h3F,  6'h00,  6'h00,  1'b0, 16'h7FF0, 0, 0, 0, 6'h00,  6'h00,  0, 0};
    vecs[1]  = '{3'd2, 16'h7EF0, 6'h3F,  6'h00,  6'h00,  1'b0, 16'h7FF0, 1, 0, 0, 6'h00,  6'h00,  1, 0};
    vecs[2]  = '{3'd2, 16'h1000, 6'h00,  6'h02,  6'h00,  1'b0, 16'h1100, 0, 1, 0, 6'h02,  6'h00,  1, 1};
    vecs[3]  = '{3'd2, 16'h1000, 6'h02,  6'h00,  6'h03,  1'b0, 16'h1100, 1, 0, 1, 6'h02,  6'h03,  2, 2};
    vecs[4]  = '{3'd2, 16'h1000, 6'h00,  6'h02,  6'h02,  1'b0, 16'h1100, 0, 1, 1, 6'h02,  6'h03,  2, 3};
    vecs[5]  = '{3'd4, 16'h2000, 6'h3F,  6'h00,  6'h00,  1'b0, 16'h2300, 0, 0, 0, 6'h02,  6'h03,  0, 0};
    vecs[6]  = '{3'd4, 16'h2000, 6'h3F,  6'h00,  6'h00,  1'b0, 16'h2300, 1, 0, 0, 6'h02,  6'h03,  1, 0};
    vecs[7]  = '{3'd1, 16'h3000, 6'h3F,  6'h20,  6'h00,  1'b1, 16'h3000, 0, 0, 0, 6'h20,  6'h00,  0, 0};
    vecs[8]  = '{3'd1, 16'h3000, 6'h01,  6'h00,  6'h00,  1'b0, 16'h3000, 1, 0, 0, 6'h20,  6'h00,  1, 0};
    vecs[9]  = '{3'd7, 16'h4000, 6'h3F,  6'h3F,  6'h00,  1'b1, 16'h0000, 0, 0, 0, 6'h3F,  6'h00,  0, 0};
    vecs[10] = '{3'd0, 16'h4000, 6'h3F,  6'h00,  6'h00,  1'b1, 16'h0000, 0, 0, 0, 6'h00,  6'h00,  0, 0};
    vecs[11] = '{3'd6, 16'h5000, 6'h20,  6'h00,  6'h20,  1'b0, 16'h5500, 0, 0, 1, 6'h00,  6'h20,  0, 0};
    vecs[12] = '{3'd6, 16'h5000, 6'h20,  6'h00,  6'h20,  1'b0, 16'h5500, 1, 0, 1, 6'h00,  6'h20,  1, 1};

    // Reset with everything active.
    rst = 1'b1; out_sel = 3'd3; clr_sticky = 1'b0; cap_arm = 1'b1; cap_trig_mode = 1'b0;
    cap_rd_addr = '0;
    set_taps(16'h1234, 6'h3F, 6'h3F, 6'h3F);
    step(); step();
    check("rst_mon_out", mon_out, 0);
    check("rst_mon_valid", mon_valid, 0);
    check("rst_mon_ovf", mon_ovf, 0);
    check("rst_mon_unf", mon_unf, 0);
    check("rst_sticky_ovf", sticky_ovf, 0);
    check("rst_sticky_unf", sticky_unf, 0);
    check("rst_valid_cnt", valid_cnt, 0);
    check("rst_event_cnt", event_cnt, 0);
    check("rst_cap_state", cap_state, 0);
    check("rst_cap_rd_data", cap_rd_data, 0);
    rst = 1'b0; cap_arm = 1'b0;

    for (int i = 0; i < 13; i++) begin
      out_sel = vecs[i].sel; clr_sticky = vecs[i].clr;
      set_taps(vecs[i].base, vecs[i].v, vecs[i].o, vecs[i].u);
      step();
      check($sformatf("v%0d_mon_out", i), mon_out, vecs[i].e_out);
      check($sformatf("v%0d_mon_valid", i), mon_valid, vecs[i].e_v);
      check($sformatf("v%0d_mon_ovf", i), mon_ovf, vecs[i].e_o);
      check($sformatf("v%0d_mon_unf", i), mon_unf, vecs[i].e_u);
      check($sformatf("v%0d_sticky_ovf", i), sticky_ovf, vecs[i].e_so);
      check($sformatf("v%0d_sticky_unf", i), sticky_unf, vecs[i].e_su);
      check($sformatf("v%0d_valid_cnt", i), valid_cnt, vecs[i].e_vc);
      check($sformatf("v%0d_event_cnt", i), event_cnt, vecs[i].e_ec);
    end
    clr_sticky = 1'b0;

    // Capture, trigger on next valid.
    out_sel = 3'd2; set_all(16'h0, 6'h00, 6'h00);
    step();
    check("m0_idle", cap_state, 0);
    cap_arm = 1'b1; step(); cap_arm = 1'b0;
    check("m0_armed", cap_state, 1);
    for (int i = 0; i < 40; i++) begin
      set_all(16'(i), 6'h3F, 6'h00);
      step();
      if (i == 30) check("m0_fill_at30", cap_state, 2);
      if (i == 31) check("m0_done_at31", cap_state, 3);
    end
    set_all(16'h0, 6'h00, 6'h00);
    step();
    check("m0_done_hold", cap_state, 3);
    for (int a = 0; a < 32; a++) begin
      cap_rd_addr = 5'(a);
      step();
      check($sformatf("m0_rd%0d", a), cap_rd_data, a);
    end

    // Capture, trigger on valid with overflow.
    cap_trig_mode = 1'b1;
    cap_arm = 1'b1; step(); cap_arm = 1'b0;
    check("m1_rearm", cap_state, 1);
    set_all(16'hBEEF, 6'h00, 6'h3F);
    step();
    check("m1_ovf_no_valid", cap_state, 1);
    for (int i = 0; i < 15; i++) begin
      set_all(16'(i), 6'h3F, (i == 9) ? 6'h3F : 6'h00);
      step();
      if (i == 8) check("m1_armed_at8", cap_state, 1);
      if (i == 9) check("m1_fill_at9", cap_state, 2);
    end
    set_all(16'h0, 6'h00, 6'h00);
    cap_rd_addr = 5'd0; step();
    check("m1_rd0", cap_rd_data, 9);
    cap_rd_addr = 5'd5; step();
    check("m1_rd5", cap_rd_data, 14);
    check("m1_still_fill", cap_state, 2);
    out_sel = 3'd3; step();
    check("m1_sel_abort", cap_state, 0);

    // Arm ignored with nothing selected.
    out_sel = 3'd0; step();
    cap_arm = 1'b1; step(); cap_arm = 1'b0;
    check("arm_sel0_ignored", cap_state, 0);

    // Reset mid-capture.
    cap_trig_mode = 1'b0;
    out_sel = 3'd2; step();
    cap_arm = 1'b1; step(); cap_arm = 1'b0;
    set_all(16'h55, 6'h3F, 6'h00); step();
    check("rstcap_fill", cap_state, 2);
    rst = 1'b1; step(); rst = 1'b0;
    check("rstcap_idle", cap_state, 0);
    check("rstcap_mon_valid", mon_valid, 0);

    // Counter saturation: change cycle clears, then 2^16+5 valid/ovf cycles.
    set_all(16'h0, 6'h3F, 6'h3F);
    step();
    check("sat_start", valid_cnt, 0);
    for (int i = 0; i < 65541; i++) begin
      step();
      if (i == 99) check("sat_cnt100", valid_cnt, 100);
    end
    check("sat_valid_cnt", valid_cnt, 16'hFFFF);
    check("sat_event_cnt", event_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
